// File: rtl/line_buf_ctrl_if.sv
// line_buf_ctrl_if: video timing inputs and line-RAM control outputs of the
// line shift buffer sequencer, bundled for connection to line_buf_ctrl.
interface line_buf_ctrl_if #(
  parameter int AW = 10,
  parameter int RW = 11
);
  logic          vs;
  logic          hs;
  logic          de;
  logic [AW-1:0] ram_rd_addr;
  logic [AW-1:0] ram_wr_addr;
  logic          ram0_wr_en;
  logic          ram1_wr_en;
  logic [AW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          win_valid;
  logic          border;
  logic          ovf;
  logic [AW-1:0] line_width;
  logic          width_err;

  // Video source / observer side
  modport master (
    output vs, hs, de,
    input  ram_rd_addr, ram_wr_addr, ram0_wr_en, ram1_wr_en, col_cnt, row_cnt,
    input  win_valid, border, ovf, line_width, width_err
  );

  // Sequencer side
  modport slave (
    input  vs, hs, de,
    output ram_rd_addr, ram_wr_addr, ram0_wr_en, ram1_wr_en, col_cnt, row_cnt,
    output win_valid, border, ovf, line_width, width_err
  );
endinterface

// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: sequencer for the two-RAM 3-row line shift buffer.
// Produces RAM read/write addresses and write enables, tracks column/row
// position in the frame and flags complete 3x3 windows.
// Optional line statistics (line_width / width_err) are built only when the
// macro LINE_BUF_STAT_EN is defined; otherwise those outputs are tied to 0.
module line_buf_ctrl #(
  parameter int AW   = 10,
  parameter int RW   = 11,
  parameter int PIPE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  line_buf_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] COL_FULL  = AW'(2);
  localparam logic [RW-1:0] ROW_MAX   = {RW{1'b1}};
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [RW-1:0] ROW_READY = RW'(2);

  state_t                  state_q, state_d;
  logic                    vs_q, vs_d;
  logic                    hs_q, hs_d;
  logic                    abort_q, abort_d;
  logic                    seen_q, seen_d;
  logic                    sat_q, sat_d;
  logic                    ovf_q, ovf_d;
  logic [AW-1:0]           rd_addr_q, rd_addr_d;
  logic [RW-1:0]           row_cnt_q, row_cnt_d;
  logic [AW-1:0]           col_q, col_d;
  logic [PIPE-1:0]         we_pipe_q, we_pipe_d;
  logic [PIPE-1:0][AW-1:0] wa_pipe_q, wa_pipe_d;

  logic vs_rise_s, hs_fall_s, pix_s, active_s;
  logic wr_en_s, win_s, border_s;

  assign vs_d      = bus.vs;
  assign hs_d      = bus.hs;
  assign vs_rise_s = bus.vs & ~vs_q;
  assign hs_fall_s = hs_q & ~bus.hs;
  assign active_s  = (state_q != ST_IDLE);
  // A pixel counts only inside hs, outside an aborted line, and not on the frame-start cycle.
  assign pix_s     = bus.hs & bus.de & ~abort_q & ~vs_rise_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: frame start always restarts filling; RUN once two rows are stored
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = vs_rise_s ? ST_FILL : ST_IDLE;
      ST_FILL: begin
        if (vs_rise_s) begin
          state_d = ST_FILL;
        end else if (row_cnt_q >= ROW_READY) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_RUN:  state_d = vs_rise_s ? ST_FILL : ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: write enable gated outside a frame, column aligned to the write, window flags
  always_comb begin
    wr_en_s  = we_pipe_q[PIPE-1] & active_s;
    col_d    = wr_en_s ? wa_pipe_q[PIPE-1] : col_q;
    win_s    = wr_en_s & (state_q == ST_RUN) & (col_d >= COL_FULL);
    border_s = wr_en_s & ((col_d == '0) | (row_cnt_q < ROW_READY));
  end

  // Line position: read address with saturation, overflow, row count, aborted-line tracking
  always_comb begin
    rd_addr_d = rd_addr_q;
    sat_d     = sat_q;
    seen_d    = seen_q;
    ovf_d     = ovf_q;
    row_cnt_d = row_cnt_q;
    abort_d   = abort_q;
    if (vs_rise_s) begin
      // Frame start wins over any row increment on the same cycle.
      rd_addr_d = '0;
      sat_d     = 1'b0;
      seen_d    = 1'b0;
      ovf_d     = 1'b0;
      row_cnt_d = '0;
      abort_d   = bus.hs;
    end else begin
      if (!bus.hs) begin
        rd_addr_d = '0;
        sat_d     = 1'b0;
        seen_d    = 1'b0;
        abort_d   = 1'b0;
      end else if (pix_s) begin
        seen_d = 1'b1;
        if (rd_addr_q == ADDR_MAX) begin
          // First pixel at the last address is legal; any further one overflows.
          sat_d = 1'b1;
          ovf_d = ovf_q | (sat_q & active_s);
        end else begin
          rd_addr_d = rd_addr_q + ADDR_ONE;
        end
      end else begin
        rd_addr_d = rd_addr_q;
      end
      if (hs_fall_s && seen_q && active_s && (row_cnt_q != ROW_MAX)) begin
        row_cnt_d = row_cnt_q + ROW_ONE;
      end else begin
        row_cnt_d = row_cnt_q;
      end
    end
  end

  // Write delay line: the write of a pixel follows its read by PIPE cycles
  always_comb begin
    we_pipe_d    = we_pipe_q;
    wa_pipe_d    = wa_pipe_q;
    we_pipe_d[0] = pix_s;
    wa_pipe_d[0] = rd_addr_q;
    for (int i = 1; i < PIPE; i++) begin
      we_pipe_d[i] = we_pipe_q[i-1];
      wa_pipe_d[i] = wa_pipe_q[i-1];
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      abort_q   <= 1'b0;
      seen_q    <= 1'b0;
      sat_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_addr_q <= '0;
      row_cnt_q <= '0;
      col_q     <= '0;
      we_pipe_q <= '0;
      wa_pipe_q <= '0;
    end else begin
      vs_q      <= vs_d;
      hs_q      <= hs_d;
      abort_q   <= abort_d;
      seen_q    <= seen_d;
      sat_q     <= sat_d;
      ovf_q     <= ovf_d;
      rd_addr_q <= rd_addr_d;
      row_cnt_q <= row_cnt_d;
      col_q     <= col_d;
      we_pipe_q <= we_pipe_d;
      wa_pipe_q <= wa_pipe_d;
    end
  end

  assign bus.ram_rd_addr = rd_addr_q;
  assign bus.ram_wr_addr = wa_pipe_q[PIPE-1];
  assign bus.ram0_wr_en  = wr_en_s;
  assign bus.ram1_wr_en  = wr_en_s;
  assign bus.col_cnt     = col_d;
  assign bus.row_cnt     = row_cnt_q;
  assign bus.win_valid   = win_s;
  assign bus.border      = border_s;
  assign bus.ovf         = ovf_q;

`ifdef LINE_BUF_STAT_EN
  logic [AW-1:0] px_cnt_q, px_cnt_d;
  logic [AW-1:0] line_width_q, line_width_d;
  logic          width_err_q, width_err_d;

  // Line statistics: saturating pixel count, width latched at line end, width change flag
  always_comb begin
    px_cnt_d     = px_cnt_q;
    line_width_d = line_width_q;
    width_err_d  = width_err_q;
    if (!bus.hs || vs_rise_s) begin
      px_cnt_d = '0;
    end else if (pix_s && (px_cnt_q != ADDR_MAX)) begin
      px_cnt_d = px_cnt_q + ADDR_ONE;
    end else begin
      px_cnt_d = px_cnt_q;
    end
    if (hs_fall_s && seen_q && active_s) begin
      line_width_d = px_cnt_q;
      if ((row_cnt_q != '0) && (px_cnt_q != line_width_q)) begin
        width_err_d = 1'b1;
      end else begin
        width_err_d = width_err_q;
      end
    end else begin
      line_width_d = line_width_q;
    end
    if (vs_rise_s) begin
      width_err_d = 1'b0;
    end else begin
      width_err_d = width_err_d;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_cnt_q     <= '0;
      line_width_q <= '0;
      width_err_q  <= 1'b0;
    end else begin
      px_cnt_q     <= px_cnt_d;
      line_width_q <= line_width_d;
      width_err_q  <= width_err_d;
    end
  end

  assign bus.line_width = line_width_q;
  assign bus.width_err  = width_err_q;
`else
  assign bus.line_width = '0;
  assign bus.width_err  = 1'b0;
`endif

endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: directed + randomized stimulus for line_buf_ctrl, checked
// every cycle against a pixel-count based behavioural model.
module tb_line_buf_ctrl;
  localparam int AW   = 10;
  localparam int RW   = 11;
  localparam int PIPE = 2;
  localparam int AMAX = (1 << AW) - 1;
  localparam int RMAX = (1 << RW) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  line_buf_ctrl_if #(.AW(AW), .RW(RW)) bus();

  line_buf_ctrl #(.AW(AW), .RW(RW), .PIPE(PIPE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int win_cnt  = 0;
  int wr_cnt   = 0;

  // Model: m_n = pixels accepted so far in the current line; frame state 0 idle/1 fill/2 run
  int m_state = 0;
  int m_n     = 0;
  int m_row   = 0;
  int m_col   = 0;
  int m_lw    = 0;
  bit m_ovf = 1'b0, m_err = 1'b0, m_abort = 1'b0, m_vs_prev = 1'b0, m_hs_prev = 1'b0;
  bit m_weq[$];
  int m_waq[$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int sat_addr(int n);
    return (n > AMAX) ? AMAX : n;
  endfunction

  function automatic bit e_wr();
    return (m_state != 0) && m_weq[0];
  endfunction

  function automatic int e_col();
    return e_wr() ? m_waq[0] : m_col;
  endfunction

  task automatic m_reset();
    m_state = 0; m_n = 0; m_row = 0; m_col = 0; m_lw = 0;
    m_ovf = 1'b0; m_err = 1'b0; m_abort = 1'b0; m_vs_prev = 1'b0; m_hs_prev = 1'b0;
    m_weq.delete();
    m_waq.delete();
    for (int i = 0; i < PIPE; i++) begin
      m_weq.push_back(1'b0);
      m_waq.push_back(0);
    end
  endtask

  // Behavioural model update on each active edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      bit vr, hf, pix, act;
      int n_old, row_old;
      vr      = bus.vs && !m_vs_prev;
      hf      = m_hs_prev && !bus.hs;
      pix     = bus.hs && bus.de && !m_abort && !vr;
      act     = (m_state != 0);
      n_old   = m_n;
      row_old = m_row;
      m_col   = e_col();
      m_weq.push_back(pix);
      m_waq.push_back(sat_addr(n_old));
      void'(m_weq.pop_front());
      void'(m_waq.pop_front());
      if (pix && act && n_old > AMAX) m_ovf = 1'b1;
      if (!bus.hs || vr) m_n = 0;
      else if (pix) m_n = n_old + 1;
      if (hf && n_old > 0 && act) begin
        if (m_row < RMAX) m_row++;
`ifdef LINE_BUF_STAT_EN
        if (row_old != 0 && sat_addr(n_old) != m_lw) m_err = 1'b1;
        m_lw = sat_addr(n_old);
`endif
      end
      if (vr) begin
        m_row = 0; m_ovf = 1'b0; m_err = 1'b0;
      end
      if (!bus.hs) m_abort = 1'b0;
      else if (vr) m_abort = 1'b1;
      if (vr) m_state = 1;
      else if (m_state == 1 && row_old >= 2) m_state = 2;
      m_vs_prev = bus.vs;
      m_hs_prev = bus.hs;
    end
  end

  // Compare DUT against model on the inactive edge
  always @(negedge clk) begin
    if (chk_en) begin
      bit ew;
      int ec;
      ew = e_wr();
      ec = e_col();
      chk("rd_addr",    bus.ram_rd_addr, sat_addr(m_n));
      chk("wr_addr",    bus.ram_wr_addr, m_waq[0]);
      chk("wr_en0",     bus.ram0_wr_en,  ew);
      chk("wr_en1",     bus.ram1_wr_en,  ew);
      chk("col_cnt",    bus.col_cnt,     ec);
      chk("row_cnt",    bus.row_cnt,     m_row);
      chk("win_valid",  bus.win_valid,   ew && m_state == 2 && ec >= 2);
      chk("border",     bus.border,      ew && (ec == 0 || m_row < 2));
      chk("ovf",        bus.ovf,         m_ovf);
      chk("line_width", bus.line_width,  m_lw);
      chk("width_err",  bus.width_err,   m_err);
      if (bus.win_valid)  win_cnt++;
      if (bus.ram0_wr_en) wr_cnt++;
    end
  end

  task automatic cyc(bit v, bit h, bit d);
    @(posedge clk);
    #2;
    bus.vs = v;
    bus.hs = h;
    bus.de = d;
  endtask

  // Blanking with random de, which must be ignored
  task automatic gap(int n);
    repeat (n) cyc(1'b0, 1'b0, 1'(($urandom_range(0, 1))));
  endtask

  task automatic vs_pulse();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    gap(3);
  endtask

  // mode 0 dense, 1 alternate on/off, 2 random; vs_at = cycle index of a mid-line vs pulse
  task automatic send_line(int npx, int mode, int gapn, int vs_at, bit vs_end);
    int k = 0;
    int j = 0;
    bit d;
    while (k < npx) begin
      case (mode)
        0:       d = 1'b1;
        1:       d = (j % 2 == 0);
        default: d = ($urandom_range(0, 3) != 0);
      endcase
      cyc(j == vs_at, 1'b1, d);
      if (d) k++;
      j++;
    end
    cyc(vs_end, 1'b0, 1'b0);
    gap(gapn - 1);
  endtask

  initial begin
    int nl, w, wf;
    bus.vs = 1'b0;
    bus.hs = 1'b0;
    bus.de = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_rd_addr", bus.ram_rd_addr, 0);
    chk("rst_wr_en",   bus.ram0_wr_en,  0);
    chk("rst_row",     bus.row_cnt,     0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // No frame start: pixels must not be written
    wr_cnt = 0;
    send_line(8, 0, 10, -1, 1'b0);
    chk("idle_wr_cnt", wr_cnt, 0);
    chk("idle_row", bus.row_cnt, 0);

    // Four dense 640-pixel lines
    vs_pulse();
    for (int r = 0; r < 4; r++) begin
      win_cnt = 0;
      wr_cnt  = 0;
      send_line(640, 0, 20, -1, 1'b0);
      chk("line_wr_cnt",  wr_cnt,      640);
      chk("line_win_cnt", win_cnt,     (r >= 2) ? 638 : 0);
      chk("line_row",     bus.row_cnt, r + 1);
    end

    // de gaps mid-line
    win_cnt = 0;
    wr_cnt  = 0;
    send_line(640, 1, 20, -1, 1'b0);
    chk("gap_wr_cnt",  wr_cnt,  640);
    chk("gap_win_cnt", win_cnt, 638);

    // Over-long line
    wr_cnt = 0;
    send_line(1030, 0, 20, -1, 1'b0);
    chk("long_wr_cnt", wr_cnt,  1030);
    chk("long_ovf",    bus.ovf, 1);
    vs_pulse();
    chk("ovf_cleared", bus.ovf,     0);
    chk("new_row",     bus.row_cnt, 0);

    // Reset in the middle of line 3
    send_line(640, 0, 20, -1, 1'b0);
    send_line(640, 0, 20, -1, 1'b0);
    send_line(640, 0, 20, -1, 1'b0);
    repeat (100) cyc(1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rd",  bus.ram_rd_addr, 0);
    chk("mid_rst_row", bus.row_cnt,     0);
    chk("mid_rst_wr",  bus.ram0_wr_en,  0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    gap(10);
    wr_cnt = 0;
    send_line(640, 0, 20, -1, 1'b0);
    chk("post_rst_wr_cnt", wr_cnt, 0);
    vs_pulse();
    wr_cnt = 0;
    send_line(640, 0, 20, -1, 1'b0);
    chk("resume_wr_cnt", wr_cnt, 640);

    // Line width statistics
    vs_pulse();
    send_line(640, 0, 20, -1, 1'b0);
    send_line(640, 0, 20, -1, 1'b0);
`ifdef LINE_BUF_STAT_EN
    chk("stat_width_a", bus.line_width, 640);
    chk("stat_err_a",   bus.width_err,  0);
`else
    chk("stat_width_a", bus.line_width, 0);
`endif
    send_line(600, 0, 20, -1, 1'b0);
`ifdef LINE_BUF_STAT_EN
    chk("stat_width_b", bus.line_width, 600);
    chk("stat_err_b",   bus.width_err,  1);
`else
    chk("stat_width_b", bus.line_width, 0);
    chk("stat_err_b",   bus.width_err,  0);
`endif

    // Randomized frames: varying widths, de density, short gaps, aborts, coincident vs/hs fall
    for (int f = 0; f < 6; f++) begin
      vs_pulse();
      nl = $urandom_range(2, 5);
      wf = $urandom_range(1, 700);
      for (int l = 0; l < nl; l++) begin
        if ($urandom_range(0, 7) == 0) w = $urandom_range(1020, 1040);
        else if ($urandom_range(0, 3) == 0) w = $urandom_range(1, 700);
        else w = wf;
        send_line(w, $urandom_range(0, 2), $urandom_range(3, 25),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, w - 1) : -1,
                  ($urandom_range(0, 9) == 0));
      end
    end
    gap(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
